// File: rtl/cmd_fifo_pkg.sv
// Shared widths, field offsets and FSM state encoding for the command CDC FIFO write side.
// Packed command layout (MSB first): {id, we, addr, wdata, wmask}.
package cmd_fifo_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 128;
  localparam int unsigned MASK_W = 16;
  localparam int unsigned ID_W   = 2;
  localparam int unsigned CMD_W  = ID_W + 1 + ADDR_W + DATA_W + MASK_W;

  localparam int unsigned MASK_LSB = 0;
  localparam int unsigned DATA_LSB = MASK_LSB + MASK_W;
  localparam int unsigned ADDR_LSB = DATA_LSB + DATA_W;
  localparam int unsigned WE_BIT   = ADDR_LSB + ADDR_W;
  localparam int unsigned ID_LSB   = WE_BIT + 1;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  function automatic logic [CMD_W-1:0] pack_cmd(logic [ID_W-1:0] id, logic we,
                                                 logic [ADDR_W-1:0] addr,
                                                 logic [DATA_W-1:0] wdata,
                                                 logic [MASK_W-1:0] wmask);
    return {id, we, addr, wdata, wmask};
  endfunction

endpackage

// File: rtl/cmd_fifo_arbiter_if.sv
// Requester-side valid/ready bundle plus FIFO write port of the command arbiter.
// master = requesters/FIFO side, slave = arbiter.
interface cmd_fifo_arbiter_if
  import cmd_fifo_pkg::*;
#(
  parameter int unsigned NREQ = 4
);

  logic [NREQ-1:0]        in_valid;
  logic [NREQ-1:0]        in_ready;
  logic [NREQ-1:0]        in_last;
  logic [NREQ-1:0]        in_we;
  logic [NREQ*ADDR_W-1:0] in_addr;
  logic [NREQ*DATA_W-1:0] in_wdata;
  logic [NREQ*MASK_W-1:0] in_wmask;
  logic                   fifo_full;
  logic                   fifo_wr_en;
  logic [CMD_W-1:0]       fifo_data;
  logic [ID_W-1:0]        owner;
  logic                   busy;

  modport master (
    output in_valid, in_last, in_we, in_addr, in_wdata, in_wmask, fifo_full,
    input  in_ready, fifo_wr_en, fifo_data, owner, busy
  );

  modport slave (
    input  in_valid, in_last, in_we, in_addr, in_wdata, in_wmask, fifo_full,
    output in_ready, fifo_wr_en, fifo_data, owner, busy
  );

endinterface

// File: rtl/cmd_rr_pick.sv
// Combinational round-robin picker: returns the first requester strictly after i_last_ptr
// (modulo NREQ) whose request bit is set.
module cmd_rr_pick
  import cmd_fifo_pkg::*;
#(
  parameter int unsigned NREQ = 4
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [ID_W-1:0] i_last_ptr,
  output logic            o_found,
  output logic [ID_W-1:0] o_idx
);

  int unsigned w_best;

  // Distance from last_ptr: last_ptr+1 is 0, last_ptr itself is NREQ-1.
  always_comb begin
    o_found = 1'b0;
    o_idx   = '0;
    w_best  = NREQ;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (i_req[i] && (((i + NREQ - 1 - 32'(i_last_ptr)) % NREQ) < w_best)) begin
        w_best  = (i + NREQ - 1 - 32'(i_last_ptr)) % NREQ;
        o_idx   = ID_W'(i);
        o_found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cmd_fifo_arbiter.sv
// Write-side arbiter for the 179-bit command CDC FIFO: one owner per burst, round-robin.
// Define CMD_ARB_PRIO_EN to give requester 0 fixed priority over the rotating others.
module cmd_fifo_arbiter
  import cmd_fifo_pkg::*;
#(
  parameter int unsigned NREQ      = 4,
  parameter int unsigned BURST_MAX = 8
) (
  input logic               clk_25MHz,
  input logic               rstn,
  cmd_fifo_arbiter_if.slave io_cmd
);

  localparam logic [0:0]       S_IDLE   = 1'(IDLE);
  localparam logic [0:0]       S_GRANT  = 1'(GRANT);
  localparam int unsigned      CNT_W    = 4;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST_MAX - 1);

  logic [0:0]       r_state,    w_state_nxt;
  logic [ID_W-1:0]  r_owner,    w_owner_nxt;
  logic [ID_W-1:0]  r_last_ptr, w_ptr_nxt;
  logic [CNT_W-1:0] r_beat_cnt, w_cnt_nxt;

  logic [NREQ-1:0]  w_pick_req;
  logic             w_rr_found, w_sel_found;
  logic [ID_W-1:0]  w_rr_idx,   w_sel_idx;
  logic             w_upd_ptr;
  logic             w_grant, w_own_valid, w_own_last, w_accept, w_release;
  logic [CMD_W-1:0] w_cmd;

  cmd_rr_pick #(
    .NREQ (NREQ)
  ) u_pick (
    .i_req      (w_pick_req),
    .i_last_ptr (r_last_ptr),
    .o_found    (w_rr_found),
    .o_idx      (w_rr_idx)
  );

`ifdef CMD_ARB_PRIO_EN
  // Requester 0 bypasses the rotation and never moves last_ptr.
  assign w_pick_req  = io_cmd.in_valid & ~NREQ'(1);
  assign w_sel_found = io_cmd.in_valid[0] | w_rr_found;
  assign w_sel_idx   = io_cmd.in_valid[0] ? '0 : w_rr_idx;
  assign w_upd_ptr   = (r_owner != '0);
`else
  assign w_pick_req  = io_cmd.in_valid;
  assign w_sel_found = w_rr_found;
  assign w_sel_idx   = w_rr_idx;
  assign w_upd_ptr   = 1'b1;
`endif

  assign w_grant = (r_state == S_GRANT);

  // Only the registered owner's lane reaches the outputs.
  always_comb begin
    w_own_valid = 1'b0;
    w_own_last  = 1'b0;
    w_cmd       = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (r_owner == ID_W'(i)) begin
        w_own_valid                  = io_cmd.in_valid[i];
        w_own_last                   = io_cmd.in_last[i];
        w_cmd[ID_LSB +: ID_W]        = r_owner;
        w_cmd[WE_BIT]                = io_cmd.in_we[i];
        w_cmd[ADDR_LSB +: ADDR_W]    = io_cmd.in_addr[ADDR_W*i +: ADDR_W];
        w_cmd[DATA_LSB +: DATA_W]    = io_cmd.in_wdata[DATA_W*i +: DATA_W];
        w_cmd[MASK_LSB +: MASK_W]    = io_cmd.in_wmask[MASK_W*i +: MASK_W];
      end
    end
  end

  always_comb begin
    io_cmd.in_ready = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      io_cmd.in_ready[i] = w_grant & ~io_cmd.fifo_full & (r_owner == ID_W'(i));
    end
  end

  assign w_accept  = w_grant & w_own_valid & ~io_cmd.fifo_full;
  assign w_release = w_accept & (w_own_last | (r_beat_cnt == CNT_LAST));

  assign io_cmd.fifo_wr_en = w_accept;
  assign io_cmd.fifo_data  = w_accept ? w_cmd : '0;
  assign io_cmd.owner      = r_owner;
  assign io_cmd.busy       = w_grant;

  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_ptr_nxt   = r_last_ptr;
    w_cnt_nxt   = r_beat_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_sel_found) begin
          w_owner_nxt = w_sel_idx;
          w_cnt_nxt   = '0;
          w_state_nxt = S_GRANT;
        end
      end
      S_GRANT: begin
        if (w_accept) begin
          w_cnt_nxt = r_beat_cnt + 1'b1;
          if (w_release) begin
            w_state_nxt = S_IDLE;
            if (w_upd_ptr) w_ptr_nxt = r_owner;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_25MHz or negedge rstn) begin
    if (!rstn) begin
      r_state    <= S_IDLE;
      r_owner    <= '0;
      r_last_ptr <= ID_W'(NREQ - 1);
      r_beat_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_owner    <= w_owner_nxt;
      r_last_ptr <= w_ptr_nxt;
      r_beat_cnt <= w_cnt_nxt;
    end
  end

endmodule
